exception_seq: RTL and testbench
================================

EXCEPTION_SEQ -- requirements
Module: exception_seq

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 ctrl_addr_sel  in  3  address-mux selector requested by main control.
REQ-005 exc_opcode  in  1  invalid-opcode exception request, sampled on clk.
REQ-006 exc_overflow  in  1  ALU overflow exception request, sampled on clk.
REQ-007 exc_div0  in  1  divide-by-zero exception request, sampled on clk.
REQ-008 pc_in  in  32  current PC value, already incremented by 4.
REQ-009 mem_data_in  in  32  memory read data; handler address in bits [7:0].
REQ-010 addr_sel  out  3  selector driven to the address mux.
REQ-011 mem_rd  out  1  memory read strobe.
REQ-012 epc_out  out  32  exception PC register.
REQ-013 cause  out  2  latched cause: 00 none, 01 opcode, 10 overflow, 11 div0.
REQ-014 pc_write  out  1  one-cycle PC load strobe.
REQ-015 pc_value  out  32  handler address to load into PC.
REQ-016 busy  out  1  high while sequence active; main control SHALL stall on it.

Function
REQ-017 FSM states SHALL be IDLE, SAVE, RD0, RD1, LOAD; each non-IDLE state lasts exactly one cycle, order SAVE->RD0->RD1->LOAD->IDLE.
REQ-018 IDLE: addr_sel = ctrl_addr_sel (combinational pass-through), busy=0, mem_rd=0, pc_write=0.
REQ-019 IDLE with any exc_* high at a rising edge SHALL enter SAVE and latch cause; no exc_* high -> stay IDLE.
REQ-020 Simultaneous requests SHALL resolve by fixed priority: opcode > overflow > div0.
REQ-021 Vector selector SHALL be opcode 3'b010 (addr 253), overflow 3'b011 (254), div0 3'b100 (255).
REQ-022 SAVE, RD0, RD1, LOAD: addr_sel = latched vector selector, busy=1.
REQ-023 SAVE: epc_out SHALL update at the edge leaving SAVE to pc_in - 4, modulo 2^32 (pc_in=0 -> 0xFFFFFFFC).
REQ-024 RD0, RD1: mem_rd=1; mem_data_in is valid during LOAD (two-cycle memory latency).
REQ-025 LOAD: pc_write=1 for exactly one cycle, pc_value = {24'b0, mem_data_in[7:0]}; pc_value SHALL be 0 in all other states.
REQ-026 Latency: request sampled at edge N -> pc_write high during cycle after edge N+3; IDLE again after edge N+4.
REQ-027 exc_* inputs SHALL be ignored while busy=1 (no queuing, cause/epc unchanged).
REQ-028 A request high on the edge that returns LOAD->IDLE SHALL be ignored; requests are accepted only from IDLE.
REQ-029 cause and epc_out SHALL hold their values after the sequence until the next accepted exception.

Reset
REQ-030 reset high SHALL immediately force state IDLE, epc_out=0, cause=00, mem_rd=0, pc_write=0, pc_value=0, busy=0; addr_sel follows ctrl_addr_sel.
REQ-031 reset asserted mid-sequence SHALL abort it with no pc_write pulse; operation resumes on first edge after release.

Verification
REQ-032 Idle pass-through: ctrl_addr_sel=3'b001, no exceptions -> addr_sel=3'b001, busy=0 for 10 cycles.
REQ-033 Overflow: pc_in=0x40, exc_overflow pulse, mem_data_in[7:0]=0x7A -> addr_sel=3'b011 for 4 cycles, epc_out=0x3C, cause=10, pc_write one cycle with pc_value=0x0000007A.
REQ-034 Priority: exc_opcode, exc_overflow, exc_div0 all high -> cause=01, addr_sel=3'b010.
REQ-035 Wrap: pc_in=0, exc_div0 -> epc_out=0xFFFFFFFC, addr_sel=3'b100, cause=11.
REQ-036 Busy ignore: exc_opcode accepted, exc_div0 pulsed during RD0 -> single pc_write, cause stays 01, next sequence absent.
REQ-037 Reset abort: reset during RD1 -> busy=0, no pc_write, epc_out=0, cause=00 immediately.

Source files
------------

// File: rtl/exception_seq_if.sv
// Bundle between main control / memory and the exception sequencer.
// The slave side is the sequencer itself; the master side is main control.
interface exception_seq_if;
    logic [2:0]  ctrl_addr_sel;
    logic        exc_opcode;
    logic        exc_overflow;
    logic        exc_div0;
    logic [31:0] pc_in;
    logic [31:0] mem_data_in;

    logic [2:0]  addr_sel;
    logic        mem_rd;
    logic [31:0] epc_out;
    logic [1:0]  cause;
    logic        pc_write;
    logic [31:0] pc_value;
    logic        busy;

    modport master (
        output ctrl_addr_sel,
        output exc_opcode,
        output exc_overflow,
        output exc_div0,
        output pc_in,
        output mem_data_in,
        input  addr_sel,
        input  mem_rd,
        input  epc_out,
        input  cause,
        input  pc_write,
        input  pc_value,
        input  busy
    );

    modport slave (
        input  ctrl_addr_sel,
        input  exc_opcode,
        input  exc_overflow,
        input  exc_div0,
        input  pc_in,
        input  mem_data_in,
        output addr_sel,
        output mem_rd,
        output epc_out,
        output cause,
        output pc_write,
        output pc_value,
        output busy
    );
endinterface

// File: rtl/exception_seq.sv
// Exception sequencer: saves the faulting PC, fetches the handler address
// from a fixed vector slot and loads it into the PC.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | address mux follows main control; waiting for an exception
// SAVE  | cause latched; EPC captured at the edge leaving this state
// RD0   | vector slot on the address bus, first memory latency cycle
// RD1   | second memory latency cycle
// LOAD  | memory data valid; one-cycle PC load of the handler address
module exception_seq (
    input  logic          clk,
    input  logic          reset,
    exception_seq_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SAVE = 3'd1,
        RD0  = 3'd2,
        RD1  = 3'd3,
        LOAD = 3'd4
    } state_t;

    state_t      state;
    logic [2:0]  vec_sel;
    logic [1:0]  cause_q;
    logic [31:0] epc_q;
    logic        busy_q;
    logic        mem_rd_q;
    logic        pc_write_q;

    logic        req_any;
    logic [1:0]  req_cause;
    logic [2:0]  req_vec;

    // Fixed-priority request resolution: opcode > overflow > div0.
    always_comb begin
        req_any   = bus.exc_opcode | bus.exc_overflow | bus.exc_div0;
        req_cause = 2'b00;
        req_vec   = 3'b000;
        if (bus.exc_opcode) begin
            req_cause = 2'b01;
            req_vec   = 3'b010;
        end else if (bus.exc_overflow) begin
            req_cause = 2'b10;
            req_vec   = 3'b011;
        end else if (bus.exc_div0) begin
            req_cause = 2'b11;
            req_vec   = 3'b100;
        end
    end

    // Sequencer FSM; strobes are registered from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vec_sel    <= 3'b000;
            cause_q    <= 2'b00;
            epc_q      <= 32'd0;
            busy_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            pc_write_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        state   <= SAVE;
                        cause_q <= req_cause;
                        vec_sel <= req_vec;
                        busy_q  <= 1'b1;
                    end
                end
                SAVE: begin
                    state    <= RD0;
                    epc_q    <= bus.pc_in - 32'd4;
                    mem_rd_q <= 1'b1;
                end
                RD0: begin
                    state <= RD1;
                end
                RD1: begin
                    state      <= LOAD;
                    mem_rd_q   <= 1'b0;
                    pc_write_q <= 1'b1;
                end
                LOAD: begin
                    // Requests on this edge are dropped: only IDLE accepts.
                    state      <= IDLE;
                    pc_write_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy_q     <= 1'b0;
                    mem_rd_q   <= 1'b0;
                    pc_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Output drive; the mux selector and handler address are combinational
    // because main control and memory data must pass through in-cycle.
    always_comb begin
        bus.addr_sel = busy_q ? vec_sel : bus.ctrl_addr_sel;
        bus.pc_value = pc_write_q ? {24'd0, bus.mem_data_in[7:0]} : 32'd0;
        bus.busy     = busy_q;
        bus.mem_rd   = mem_rd_q;
        bus.pc_write = pc_write_q;
        bus.epc_out  = epc_q;
        bus.cause    = cause_q;
    end

endmodule

// File: tb/tb_exception_seq.sv
// Bench for exception_seq: cycle-timeline reference model plus directed
// scenarios with literal expectations.
module tb_exception_seq;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    exception_seq_if bus ();

    exception_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference model: an accepted request at edge A makes the cycles after
    // edges A..A+3 busy, reads after A+1 and A+2, loads after A+3.
    int          edge_cnt = 0;
    int          acc_edge = -100;
    logic [1:0]  m_cause  = 2'b00;
    logic [31:0] m_epc    = 32'd0;
    logic [2:0]  vec_of [4] = '{3'b000, 3'b010, 3'b011, 3'b100};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_edge = -100;
            m_cause  = 2'b00;
            m_epc    = 32'd0;
        end else begin
            edge_cnt++;
            if (edge_cnt - acc_edge == 1)
                m_epc = bus.pc_in - 32'd4;
            if ((edge_cnt - acc_edge >= 5) &&
                (bus.exc_opcode || bus.exc_overflow || bus.exc_div0)) begin
                acc_edge = edge_cnt;
                m_cause  = bus.exc_opcode ? 2'd1 : (bus.exc_overflow ? 2'd2 : 2'd3);
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(posedge clk) begin : cmp
        int   d;
        logic m_busy;
        logic m_pw;
        #1;
        if (chk_en) begin
            d      = edge_cnt - acc_edge;
            m_busy = (d >= 0) && (d <= 3);
            m_pw   = (d == 3);
            chk("m_busy",     32'(bus.busy),     32'(m_busy));
            chk("m_mem_rd",   32'(bus.mem_rd),   32'((d == 1) || (d == 2)));
            chk("m_pc_write", 32'(bus.pc_write), 32'(m_pw));
            chk("m_pc_value", bus.pc_value, m_pw ? {24'd0, bus.mem_data_in[7:0]} : 32'd0);
            chk("m_addr_sel", 32'(bus.addr_sel),
                32'(m_busy ? vec_of[m_cause] : bus.ctrl_addr_sel));
            chk("m_cause",    32'(bus.cause),    32'(m_cause));
            chk("m_epc",      bus.epc_out,       m_epc);
        end
    end

    // One request pulse, optional extra pulse injected i cycles into the
    // sequence; counts vector cycles and PC load pulses over n_cyc cycles.
    task automatic run_seq(input logic [2:0] req, input int inj_cyc, input logic [2:0] inj,
                           input logic [2:0] vec, input int n_cyc,
                           output int vec_cnt, output int pw_cnt, output logic [31:0] pv);
        vec_cnt = 0;
        pw_cnt  = 0;
        pv      = 32'd0;
        @(negedge clk);
        {bus.exc_opcode, bus.exc_overflow, bus.exc_div0} = req;
        for (int i = 0; i < n_cyc; i++) begin
            @(negedge clk);
            if (bus.busy && bus.addr_sel == vec) vec_cnt++;
            if (bus.pc_write) begin
                pw_cnt++;
                pv = bus.pc_value;
            end
            if (i == 0)
                {bus.exc_opcode, bus.exc_overflow, bus.exc_div0} = 3'b000;
            if (i == inj_cyc)
                {bus.exc_opcode, bus.exc_overflow, bus.exc_div0} = inj;
            if (i == inj_cyc + 1)
                {bus.exc_opcode, bus.exc_overflow, bus.exc_div0} = 3'b000;
        end
    endtask

    initial begin
        int          vc;
        int          pw;
        logic [31:0] pv;

        bus.ctrl_addr_sel = 3'b001;
        bus.exc_opcode    = 1'b0;
        bus.exc_overflow  = 1'b0;
        bus.exc_div0      = 1'b0;
        bus.pc_in         = 32'd0;
        bus.mem_data_in   = 32'd0;

        repeat (3) @(negedge clk);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_pc_write", 32'(bus.pc_write), 32'd0);
        chk("rst_epc",      bus.epc_out,       32'd0);
        chk("rst_cause",    32'(bus.cause),    32'd0);
        chk("rst_addr_sel", 32'(bus.addr_sel), 32'h1);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Idle pass-through
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_addr_sel", 32'(bus.addr_sel), 32'h1);
            chk("idle_busy",     32'(bus.busy),     32'h0);
        end

        // Overflow
        bus.pc_in       = 32'h40;
        bus.mem_data_in = 32'h1234_567A;
        run_seq(3'b010, -5, 3'b000, 3'b011, 8, vc, pw, pv);
        chk("ovf_vec_cycles", 32'(vc), 32'd4);
        chk("ovf_pc_writes",  32'(pw), 32'd1);
        chk("ovf_pc_value",   pv,      32'h7A);
        chk("ovf_epc",        bus.epc_out, 32'h3C);
        chk("ovf_cause",      32'(bus.cause), 32'd2);

        // Priority: all three at once
        bus.pc_in       = 32'h200;
        bus.mem_data_in = 32'h0000_00FD;
        run_seq(3'b111, -5, 3'b000, 3'b010, 8, vc, pw, pv);
        chk("pri_vec_cycles", 32'(vc), 32'd4);
        chk("pri_cause",      32'(bus.cause), 32'd1);
        chk("pri_epc",        bus.epc_out, 32'h1FC);
        chk("pri_pc_value",   pv, 32'hFD);

        // Wrap of pc_in - 4
        bus.pc_in       = 32'h0;
        bus.mem_data_in = 32'hAABB_CCFF;
        run_seq(3'b001, -5, 3'b000, 3'b100, 8, vc, pw, pv);
        chk("wrap_epc",        bus.epc_out, 32'hFFFF_FFFC);
        chk("wrap_vec_cycles", 32'(vc), 32'd4);
        chk("wrap_cause",      32'(bus.cause), 32'd3);
        chk("wrap_pc_value",   pv, 32'hFF);

        // div0 pulsed during RD0 is ignored
        bus.pc_in       = 32'h1000;
        bus.mem_data_in = 32'h11;
        run_seq(3'b100, 1, 3'b001, 3'b010, 10, vc, pw, pv);
        chk("busy_pc_writes", 32'(pw), 32'd1);
        chk("busy_cause",     32'(bus.cause), 32'd1);
        chk("busy_epc",       bus.epc_out, 32'hFFC);
        chk("busy_idle_after", 32'(bus.busy), 32'd0);

        // Request on the LOAD->IDLE edge is ignored
        bus.pc_in = 32'h2000;
        run_seq(3'b100, 3, 3'b010, 3'b010, 10, vc, pw, pv);
        chk("ldedge_pc_writes", 32'(pw), 32'd1);
        chk("ldedge_cause",     32'(bus.cause), 32'd1);
        chk("ldedge_epc",       bus.epc_out, 32'h1FFC);

        // Reset during RD1 aborts the sequence
        bus.pc_in = 32'h300;
        @(negedge clk);
        bus.exc_opcode = 1'b1;
        @(negedge clk);
        bus.exc_opcode = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_rd1", 32'(bus.mem_rd), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy",     32'(bus.busy),     32'd0);
        chk("abort_pc_write", 32'(bus.pc_write), 32'd0);
        chk("abort_mem_rd",   32'(bus.mem_rd),   32'd0);
        chk("abort_epc",      bus.epc_out,       32'd0);
        chk("abort_cause",    32'(bus.cause),    32'd0);
        chk("abort_addr_sel", 32'(bus.addr_sel), 32'h1);
        chk("abort_pc_value", bus.pc_value,      32'd0);
        pw = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.pc_write) pw++;
        end
        chk("abort_no_load", 32'(pw), 32'd0);
        reset = 1'b0;

        // Resumes after release
        bus.pc_in       = 32'h84;
        bus.mem_data_in = 32'h5C;
        run_seq(3'b001, -5, 3'b000, 3'b100, 8, vc, pw, pv);
        chk("resume_epc",       bus.epc_out, 32'h80);
        chk("resume_cause",     32'(bus.cause), 32'd3);
        chk("resume_pc_writes", 32'(pw), 32'd1);
        chk("resume_pc_value",  pv, 32'h5C);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
